dii_packet_buffer: RTL and testbench

- Store-and-forward packet buffer between a debug module's DII output and one local port of the debug ring (`dii_in[i]`).
- Accepts 16-bit flits and holds each packet until its last flit has arrived, so the ring router never sees a stalled, partially delivered packet.
- Setting `FULLPACKET=0` turns it into a plain cut-through FIFO.
- If a packet is longer than the buffer, it is released early rather than deadlocking.

---
 rtl/dii_packet_buffer_pkg.sv | 17 +
 rtl/dii_packet_buffer_fifo_mem.sv | 27 ++
 rtl/dii_packet_buffer.sv | 143 ++++++++++++++
 tb/tb_dii_packet_buffer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dii_packet_buffer_pkg.sv
// Shared debug-interconnect types: flit bundle, flit width, buffer gating states.
// Imported by the packet buffer and its storage array.
package dii_packet_buffer_pkg;

  localparam int DII_FLIT_WIDTH = 16;

  typedef struct packed {
    logic                      last;
    logic [DII_FLIT_WIDTH-1:0] data;
  } dii_flit_t;

  typedef enum logic {
    GATED   = 1'b0,
    FORWARD = 1'b1
  } buf_state_t;

endpackage

// File: rtl/dii_packet_buffer_fifo_mem.sv
// dii_fifo_mem: DEPTH x dii_flit_t register array, one write port, async read.
// Ports: clk, i_we/i_waddr/i_wdata (write), i_raddr/o_rdata (read).
module dii_fifo_mem
  import dii_packet_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  dii_flit_t     i_wdata,
  input  logic [AW-1:0] i_raddr,
  output dii_flit_t     o_rdata
);

  dii_flit_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dii_packet_buffer.sv
// Store-and-forward DII packet buffer (cut-through FIFO when FULLPACKET=0).
// Ports: clk, rst (async low), in_* (from debug module), out_* (to ring), level, packets.
module dii_packet_buffer
  import dii_packet_buffer_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int FULLPACKET = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DII_FLIT_WIDTH-1:0] in_data,
  input  logic                      in_last,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DII_FLIT_WIDTH-1:0] out_data,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic [$clog2(DEPTH):0]    packets
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_level;
  logic [PW-1:0] r_packets;
  logic [PW-1:0] w_level_nxt;
  logic [PW-1:0] w_packets_nxt;
  buf_state_t    r_state;
  buf_state_t    w_state_nxt;

  logic      w_full;
  logic      w_empty;
  logic      w_wr;
  logic      w_rd;
  logic      w_pkt_in;
  logic      w_pkt_out;
  dii_flit_t w_wflit;
  dii_flit_t w_rflit;

  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0])
                && (r_wptr[AW] != r_rptr[AW]);
  assign w_empty = (r_wptr == r_rptr);

  assign in_ready = !w_full;
  assign w_wr     = in_valid && in_ready;
  assign w_rd     = out_valid && out_ready;

  assign w_pkt_in  = w_wr && in_last;
  assign w_pkt_out = w_rd && out_last;

  assign w_wflit = '{last: in_last, data: in_data};

  dii_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata (w_wflit),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (w_rflit)
  );

  assign out_data = w_rflit.data;
  assign out_last = w_rflit.last;
  assign level    = r_level;
  assign packets  = r_packets;

  // Full buffer releases the head packet even if incomplete, so an
  // oversize packet drains instead of deadlocking.
  always_comb begin
    out_valid = 1'b0;
    if (FULLPACKET != 0) begin
      unique case (r_state)
        GATED:   out_valid = !w_empty && ((r_packets != '0) || w_full);
        FORWARD: out_valid = !w_empty;
      endcase
    end else begin
      out_valid = !w_empty;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (FULLPACKET == 0) begin
      w_state_nxt = GATED;
    end else if (w_rd) begin
      w_state_nxt = out_last ? GATED : FORWARD;
    end
  end

  always_comb begin
    w_level_nxt = r_level;
    unique case ({w_wr, w_rd})
      2'b10:   w_level_nxt = r_level + PW'(1);
      2'b01:   w_level_nxt = r_level - PW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  always_comb begin
    w_packets_nxt = r_packets;
    unique case ({w_pkt_in, w_pkt_out})
      2'b10:   w_packets_nxt = r_packets + PW'(1);
      2'b01:   w_packets_nxt = r_packets - PW'(1);
      default: w_packets_nxt = r_packets;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_packets <= '0;
      r_state   <= GATED;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_level   <= w_level_nxt;
      r_packets <= w_packets_nxt;
      r_state   <= w_state_nxt;
    end
  end

  a_level_max: assert property (
    @(posedge clk) disable iff (!rst) r_level <= PW'(DEPTH)
  );

  a_packets_max: assert property (
    @(posedge clk) disable iff (!rst) r_packets <= PW'(DEPTH)
  );

endmodule

// File: tb/tb_dii_packet_buffer.sv
// Scoreboard bench for dii_packet_buffer: three instances
// (16 store-and-forward, 4 store-and-forward, 16 cut-through) on shared inputs.
module tb_dii_packet_buffer;
  import dii_packet_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] in_data   = '0;
  logic        in_last   = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;

  logic        a_ir, a_ov, a_ol;
  logic [15:0] a_od;
  logic [4:0]  a_lvl, a_pk;
  logic        b_ir, b_ov, b_ol;
  logic [15:0] b_od;
  logic [2:0]  b_lvl, b_pk;
  logic        c_ir, c_ov, c_ol;
  logic [15:0] c_od;
  logic [4:0]  c_lvl, c_pk;

  dii_packet_buffer #(.DEPTH(16), .FULLPACKET(1)) u16 (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid), .in_ready(a_ir),
    .out_data(a_od), .out_last(a_ol),
    .out_valid(a_ov), .out_ready(out_ready),
    .level(a_lvl), .packets(a_pk)
  );

  dii_packet_buffer #(.DEPTH(4), .FULLPACKET(1)) u4 (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid), .in_ready(b_ir),
    .out_data(b_od), .out_last(b_ol),
    .out_valid(b_ov), .out_ready(out_ready),
    .level(b_lvl), .packets(b_pk)
  );

  dii_packet_buffer #(.DEPTH(16), .FULLPACKET(0)) uct (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid), .in_ready(c_ir),
    .out_data(c_od), .out_last(c_ol),
    .out_valid(c_ov), .out_ready(out_ready),
    .level(c_lvl), .packets(c_pk)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_out = 0;
  int sel = 0;
  dii_flit_t q[$];
  dii_flit_t m_exp;

  logic        m_ir, m_ov, m_ol;
  logic [15:0] m_od;
  int          m_lvl, m_pk;

  always_comb begin
    m_ir = a_ir; m_ov = a_ov; m_ol = a_ol; m_od = a_od;
    m_lvl = int'(a_lvl); m_pk = int'(a_pk);
    case (sel)
      1: begin
        m_ir = b_ir; m_ov = b_ov; m_ol = b_ol; m_od = b_od;
        m_lvl = int'(b_lvl); m_pk = int'(b_pk);
      end
      2: begin
        m_ir = c_ir; m_ov = c_ov; m_ol = c_ol; m_od = c_od;
        m_lvl = int'(c_lvl); m_pk = int'(c_pk);
      end
      default: ;
    endcase
  end

  // Inputs only change at posedge+1, so negedge sees what the next edge commits.
  always @(negedge clk) begin
    if (rst) begin
      if (in_valid && m_ir) begin
        q.push_back('{last: in_last, data: in_data});
      end
      if (m_ov && out_ready) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_extra: got %h/%b, required no flit", m_od, m_ol);
        end else begin
          m_exp = q.pop_front();
          n_out++;
          if (m_od !== m_exp.data || m_ol !== m_exp.last) begin
            n_fail++;
            $display("FAIL scoreboard_flit: got %h/%b, required %h/%b",
                     m_od, m_ol, m_exp.data, m_exp.last);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b0;
    #2;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // Caller is at posedge+1; holds the flit until accepted.
  task automatic send(input logic [15:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = l;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (m_ir) begin ok = 1'b1; break; end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b, required 1 for %h", m_ir, d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_empty(input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (m_lvl == 0 && !m_ov) begin ok = 1'b1; break; end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_drain: level=%0d, required 0", nm, m_lvl);
    end
  endtask

  task automatic test_reset();
    sel = 0;
    rst = 1'b0;
    #1;
    n_chk++;
    if (a_ov !== 1'b0 || a_ir !== 1'b1 || a_lvl !== 5'd0 || a_pk !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_state: ov=%b ir=%b lvl=%0d pk=%0d, required 0 1 0 0",
               a_ov, a_ir, a_lvl, a_pk);
    end
    n_chk++;
    if (u16.r_state !== GATED) begin
      n_fail++;
      $display("FAIL reset_fsm: state=%0d, required GATED", u16.r_state);
    end
    do_reset();
  endtask

  task automatic test_sf_hold();
    int n0;
    sel = 0;
    do_reset();
    out_ready = 1'b1;
    n0 = n_out;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = 16'hA001 + 16'(i);
      in_last = (i == 2);
      @(negedge clk);
      n_chk++;
      if (a_ov !== 1'b0) begin
        n_fail++;
        $display("FAIL sf_hold_gated: out_valid=%b, required 0 (flit %0d)", a_ov, i);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    n_chk++;
    if (a_ov !== 1'b1 || a_pk !== 5'd1) begin
      n_fail++;
      $display("FAIL sf_release: ov=%b pk=%0d, required 1 1", a_ov, a_pk);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (n_out - n0 != 3 || a_pk !== 5'd0 || a_lvl !== 5'd0) begin
      n_fail++;
      $display("FAIL sf_done: delivered=%0d pk=%0d lvl=%0d, required 3 0 0",
               n_out - n0, a_pk, a_lvl);
    end
  endtask

  task automatic test_backpressure();
    sel = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      send(16'hF000 + 16'(i), (i % 4) == 3);
    end
    @(negedge clk);
    n_chk++;
    if (a_lvl !== 5'd16 || a_ir !== 1'b0 || a_pk !== 5'd4) begin
      n_fail++;
      $display("FAIL bp_full: lvl=%0d ir=%b pk=%0d, required 16 0 4", a_lvl, a_ir, a_pk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    n_chk++;
    if (a_lvl !== 5'd15 || a_ir !== 1'b1 || a_pk !== 5'd4) begin
      n_fail++;
      $display("FAIL bp_one_out: lvl=%0d ir=%b pk=%0d, required 15 1 4", a_lvl, a_ir, a_pk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_empty("bp");
    n_chk++;
    if (a_pk !== 5'd0 || q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_empty: pk=%0d pending=%0d, required 0 0", a_pk, q.size());
    end
  endtask

  task automatic test_oversize();
    int n0;
    sel = 1;
    do_reset();
    out_ready = 1'b1;
    n0 = n_out;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = 16'h6000 + 16'(i);
      in_last = 1'b0;
      @(negedge clk);
      n_chk++;
      if (b_ov !== 1'b0) begin
        n_fail++;
        $display("FAIL ovs_gated: out_valid=%b at level %0d, required 0", b_ov, b_lvl);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (b_ov !== 1'b1 || b_lvl !== 3'd4) begin
      n_fail++;
      $display("FAIL ovs_escape: ov=%b lvl=%0d, required 1 4", b_ov, b_lvl);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (u4.r_state !== FORWARD) begin
      n_fail++;
      $display("FAIL ovs_forward: state=%0d, required FORWARD", u4.r_state);
    end
    @(posedge clk); #1;
    send(16'h6004, 1'b0);
    send(16'h6005, 1'b1);
    wait_empty("ovs");
    n_chk++;
    if (n_out - n0 != 6 || u4.r_state !== GATED || b_pk !== 3'd0) begin
      n_fail++;
      $display("FAIL ovs_done: delivered=%0d state=%0d pk=%0d, required 6 GATED 0",
               n_out - n0, u4.r_state, b_pk);
    end
  endtask

  task automatic test_simultaneous();
    sel = 0;
    do_reset();
    send(16'hC001, 1'b1);
    send(16'hC002, 1'b0);
    @(negedge clk);
    n_chk++;
    if (a_lvl !== 5'd2 || a_pk !== 5'd1) begin
      n_fail++;
      $display("FAIL sim_setup: lvl=%0d pk=%0d, required 2 1", a_lvl, a_pk);
    end
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'hC003; in_last = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (a_ov !== 1'b1 || a_ir !== 1'b1 || a_ol !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_both: ov=%b ir=%b ol=%b, required 1 1 1", a_ov, a_ir, a_ol);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    n_chk++;
    if (a_lvl !== 5'd2 || a_pk !== 5'd1) begin
      n_fail++;
      $display("FAIL sim_counts: lvl=%0d pk=%0d, required 2 1", a_lvl, a_pk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_empty("sim");
  endtask

  task automatic test_cut_through();
    sel = 2;
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'h1234; in_last = 1'b0;
    @(negedge clk);
    n_chk++;
    if (c_ov !== 1'b0) begin
      n_fail++;
      $display("FAIL ct_empty: out_valid=%b, required 0", c_ov);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (c_ov !== 1'b1 || c_od !== 16'h1234 || a_ov !== 1'b0) begin
      n_fail++;
      $display("FAIL ct_next: ov=%b data=%h sf_ov=%b, required 1 1234 0", c_ov, c_od, a_ov);
    end
    wait_empty("ct");
  endtask

  task automatic test_mid_reset();
    sel = 0;
    do_reset();
    send(16'hE001, 1'b0);
    send(16'hE002, 1'b1);
    send(16'hE003, 1'b0);
    send(16'hE004, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    n_chk++;
    if (u16.r_state !== FORWARD || a_lvl !== 5'd3) begin
      n_fail++;
      $display("FAIL mr_setup: state=%0d lvl=%0d, required FORWARD 3", u16.r_state, a_lvl);
    end
    #1;
    rst = 1'b0;
    #1;
    n_chk++;
    if (a_lvl !== 5'd0 || a_pk !== 5'd0 || a_ov !== 1'b0 || a_ir !== 1'b1) begin
      n_fail++;
      $display("FAIL mr_async: lvl=%0d pk=%0d ov=%b ir=%b, required 0 0 0 1",
               a_lvl, a_pk, a_ov, a_ir);
    end
    q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (u16.r_state !== GATED || a_lvl !== 5'd0 || a_ov !== 1'b0) begin
      n_fail++;
      $display("FAIL mr_after: state=%0d lvl=%0d ov=%b, required GATED 0 0",
               u16.r_state, a_lvl, a_ov);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sf_hold();
    test_backpressure();
    test_oversize();
    test_simultaneous();
    test_cut_through();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
